// File: rtl/fft_frame_loader_pkg.sv
// Shared constants, reader state encoding and address helper for the FFT frame loader.
package fft_frame_loader_pkg;

    localparam int BIT_WIDTH = 16;
    localparam int N         = 9;
    localparam int FFT_SIZE  = 512;

    localparam logic [N-1:0] LAST_IDX = N'(FFT_SIZE - 1);

    typedef logic [1:0] loader_state_t;

    localparam loader_state_t S_IDLE  = 2'd0;
    localparam loader_state_t S_PRIME = 2'd1;
    localparam loader_state_t S_LOAD  = 2'd2;
    localparam loader_state_t S_RUN   = 2'd3;

    function automatic logic [N:0] bank_addr(input logic bank, input logic [N-1:0] idx);
        return {bank, idx};
    endfunction

endpackage

// File: rtl/fft_frame_loader_if.sv
// Sample capture and fftfull load bus; master drives samples and fft_done, slave is the loader.
interface fft_frame_loader_if #(
    parameter int ADC_WIDTH = 12
);
    import fft_frame_loader_pkg::*;

    logic                 sample_valid;
    logic [ADC_WIDTH-1:0] sample_in;
    logic                 fft_done;
    logic                 fft_load;
    logic [N-1:0]         add_rd;
    logic [BIT_WIDTH-1:0] din;
    logic                 fft_start;
    logic                 busy;
    logic                 overrun;

    modport master (
        output sample_valid, sample_in, fft_done,
        input  fft_load, add_rd, din, fft_start, busy, overrun
    );

    modport slave (
        input  sample_valid, sample_in, fft_done,
        output fft_load, add_rd, din, fft_start, busy, overrun
    );

endinterface

// File: rtl/fft_frame_loader_frame_bank_ram.sv
// Ping-pong frame storage: simple dual-port RAM, synchronous write, registered read.
module frame_bank_ram #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    // Storage array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_frame_loader.sv
// Captures ADC samples into a ping-pong buffer and streams each full frame into fftfull.
module fft_frame_loader
    import fft_frame_loader_pkg::*;
#(
    parameter int ADC_WIDTH    = 12,
    parameter bit ADC_UNSIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    fft_frame_loader_if.slave bus
);

    localparam logic [ADC_WIDTH-1:0] MSB_MASK = {1'b1, {(ADC_WIDTH-1){1'b0}}};

    logic [ADC_WIDTH-1:0] conv_s;
    logic [BIT_WIDTH-1:0] wr_data_s;
    logic                 wr_full_s;
    logic                 reader_free_s;
    logic                 handoff_s;
    logic                 rd_en_s;
    logic [N:0]           rd_addr_s;
    logic [BIT_WIDTH-1:0] rd_data_s;

    logic                 wr_bank_q;
    logic [N-1:0]         wr_ptr_q;
    logic                 rd_bank_q;
    loader_state_t        state_q, state_d;
    logic [N-1:0]         add_rd_q;
    logic                 fft_load_q;
    logic                 fft_start_q;
    logic                 busy_q;
    logic                 overrun_q;

    // Offset-binary to two's complement, then left-justify into the FFT word.
    always_comb begin
        if (ADC_UNSIGNED) begin
            conv_s = bus.sample_in ^ MSB_MASK;
        end else begin
            conv_s = bus.sample_in;
        end
        wr_data_s = BIT_WIDTH'(conv_s) << (BIT_WIDTH - ADC_WIDTH);
    end

    assign wr_full_s     = bus.sample_valid && (wr_ptr_q == LAST_IDX);
    assign reader_free_s = (state_q == S_IDLE) || ((state_q == S_RUN) && bus.fft_done);
    assign handoff_s     = wr_full_s && reader_free_s;

    always_comb begin
        state_d = state_q;
        if (handoff_s) begin
            state_d = S_PRIME;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_IDLE;
                S_PRIME: state_d = S_LOAD;
                S_LOAD:  state_d = (add_rd_q == LAST_IDX) ? S_RUN : S_LOAD;
                S_RUN:   state_d = bus.fft_done ? S_IDLE : S_RUN;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Read address runs one beat ahead of add_rd to hide the registered RAM output.
    always_comb begin
        if (state_q == S_PRIME) begin
            rd_en_s   = 1'b1;
            rd_addr_s = bank_addr(rd_bank_q, '0);
        end else if ((state_q == S_LOAD) && (add_rd_q != LAST_IDX)) begin
            rd_en_s   = 1'b1;
            rd_addr_s = bank_addr(rd_bank_q, add_rd_q + N'(1));
        end else begin
            rd_en_s   = 1'b0;
            rd_addr_s = bank_addr(rd_bank_q, add_rd_q);
        end
    end

    frame_bank_ram #(
        .AW (N + 1),
        .DW (BIT_WIDTH)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .we_i    (bus.sample_valid),
        .waddr_i (bank_addr(wr_bank_q, wr_ptr_q)),
        .wdata_i (wr_data_s),
        .re_i    (rd_en_s),
        .raddr_i (rd_addr_s),
        .rdata_o (rd_data_s)
    );

    // A full frame that cannot be handed off is dropped and its bank rewritten.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_bank_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_bank_q <= 1'b0;
            overrun_q <= 1'b0;
        end else if (bus.sample_valid) begin
            if (wr_full_s) begin
                wr_ptr_q <= '0;
                if (handoff_s) begin
                    rd_bank_q <= wr_bank_q;
                    wr_bank_q <= ~wr_bank_q;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else begin
                wr_ptr_q <= wr_ptr_q + N'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            add_rd_q    <= '0;
            fft_load_q  <= 1'b0;
            fft_start_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fft_load_q  <= (state_d == S_LOAD);
            fft_start_q <= (state_d == S_RUN);
            busy_q      <= (state_d != S_IDLE);
            if (state_q == S_PRIME) begin
                add_rd_q <= '0;
            end else if ((state_q == S_LOAD) && (add_rd_q != LAST_IDX)) begin
                add_rd_q <= add_rd_q + N'(1);
            end
        end
    end

    assign bus.fft_load  = fft_load_q;
    assign bus.add_rd    = add_rd_q;
    assign bus.din       = rd_data_s;
    assign bus.fft_start = fft_start_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed bench for fft_frame_loader: a 16-bit signed instance and a 12-bit offset-binary instance.
module tb_fft_frame_loader;
    import fft_frame_loader_pkg::*;

    typedef struct {
        logic [11:0] adc;
        logic [15:0] exp_din;
    } conv_vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fft_frame_loader_if #(.ADC_WIDTH(16)) bus16 ();
    fft_frame_loader_if #(.ADC_WIDTH(12)) bus12 ();

    fft_frame_loader #(.ADC_WIDTH(16), .ADC_UNSIGNED(1'b0)) u_dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16.slave)
    );

    fft_frame_loader #(.ADC_WIDTH(12), .ADC_UNSIGNED(1'b1)) u_dut12 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus12.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Called on a negedge; returns on the first negedge after the last write (PRIME if handed off).
    task automatic feed16(input logic [15:0] base, input int gap, input int done_at);
        for (int k = 0; k < FFT_SIZE; k++) begin
            bus16.sample_valid = 1'b1;
            bus16.sample_in    = base + 16'(k);
            if (k == done_at) bus16.fft_done = 1'b1;
            @(negedge clk);
            bus16.sample_valid = 1'b0;
            bus16.fft_done     = 1'b0;
            if (k != FFT_SIZE - 1) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic check_burst(input string name, input logic [15:0] base, output int waited);
        int bad = 0;
        waited = 0;
        @(negedge clk);
        while (bus16.fft_load !== 1'b1 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        chk({name, "_started"}, 32'(waited < 3000), 32'd1);
        for (int k = 0; k < FFT_SIZE; k++) begin
            if (bus16.fft_load !== 1'b1 || bus16.add_rd !== 9'(k) || bus16.din !== base + 16'(k)) bad++;
            if (k != FFT_SIZE - 1) @(negedge clk);
        end
        chk({name, "_bad_beats"}, 32'(bad), 32'd0);
        @(negedge clk);
        chk({name, "_after_load"}, {bus16.fft_load, bus16.fft_start, bus16.add_rd, bus16.din},
            {1'b0, 1'b1, LAST_IDX, base + 16'(FFT_SIZE - 1)});
    endtask

    task automatic pulse_done();
        bus16.fft_done = 1'b1;
        @(negedge clk);
        bus16.fft_done = 1'b0;
    endtask

    initial begin
        conv_vec_t tab [6];
        int w1, w2, n_load, n_nostart;

        tab[0] = '{12'h800, 16'h0000};
        tab[1] = '{12'hFFF, 16'h7FF0};
        tab[2] = '{12'h000, 16'h8000};
        tab[3] = '{12'h801, 16'h0010};
        tab[4] = '{12'h7FF, 16'hFFF0};
        tab[5] = '{12'h123, 16'h9230};

        reset = 1'b1;
        bus16.sample_valid = 1'b0; bus16.sample_in = '0; bus16.fft_done = 1'b0;
        bus12.sample_valid = 1'b0; bus12.sample_in = '0; bus12.fft_done = 1'b0;
        @(negedge clk);
        chk("reset_16", {bus16.fft_load, bus16.add_rd, bus16.din, bus16.fft_start, bus16.busy, bus16.overrun}, 32'd0);
        chk("reset_12", {bus12.fft_load, bus12.add_rd, bus12.din, bus12.fft_start, bus12.busy, bus12.overrun}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Ramp frame: latency, beats, fft_start hold, release on fft_done.
        feed16(16'h0000, 0, -1);
        chk("ramp_prime", {bus16.fft_load, bus16.busy, bus16.fft_start}, {29'd0, 3'b010});
        check_burst("ramp", 16'h0000, w1);
        chk("ramp_latency", 32'(w1), 32'd0);
        repeat (20) @(negedge clk);
        chk("ramp_start_held", {bus16.fft_start, bus16.busy, bus16.fft_load}, {29'd0, 3'b110});
        pulse_done();
        chk("ramp_done", {bus16.fft_start, bus16.busy}, 32'd0);
        pulse_done();
        chk("idle_done_ignored", {bus16.fft_start, bus16.busy, bus16.fft_load, bus16.overrun}, 32'd0);

        // Offset-binary conversion on the 12-bit instance.
        apply_reset();
        for (int k = 0; k < FFT_SIZE; k++) begin
            bus12.sample_valid = 1'b1;
            bus12.sample_in    = (k < 6) ? tab[k].adc : 12'h800;
            @(negedge clk);
            bus12.sample_valid = 1'b0;
        end
        w1 = 0;
        @(negedge clk);
        while (bus12.fft_load !== 1'b1 && w1 < 100) begin
            @(negedge clk);
            w1++;
        end
        chk("conv_started", 32'(w1), 32'd0);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("conv_beat%0d", k), {bus12.fft_load, bus12.add_rd, bus12.din},
                {1'b1, 9'(k), tab[k].exp_din});
            @(negedge clk);
        end

        // Overrun: second frame completes while reader is loading.
        apply_reset();
        feed16(16'h1000, 0, -1);
        fork
            feed16(16'h2000, 0, -1);
            check_burst("ovr_first", 16'h1000, w1);
        join
        chk("ovr_sticky", 32'(bus16.overrun), 32'd1);
        n_load = 0;
        n_nostart = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (bus16.fft_load === 1'b1) n_load++;
            if (bus16.fft_start !== 1'b1) n_nostart++;
        end
        chk("ovr_single_burst", 32'(n_load), 32'd0);
        chk("ovr_start_held", 32'(n_nostart), 32'd0);
        pulse_done();
        chk("ovr_idle", 32'(bus16.busy), 32'd0);
        feed16(16'h3000, 0, -1);
        chk("ovr_third_prime", {bus16.busy, bus16.fft_load}, {30'd0, 2'b10});
        check_burst("ovr_third", 16'h3000, w1);
        chk("ovr_still_set", 32'(bus16.overrun), 32'd1);
        pulse_done();

        // Back-to-back: fft_done arrives during capture of the second frame.
        apply_reset();
        feed16(16'h6000, 1, -1);
        fork
            feed16(16'h7000, 1, 400);
            check_burst("b2b_first", 16'h6000, w1);
        join
        chk("b2b_prime", {bus16.busy, bus16.fft_start, bus16.fft_load}, {29'd0, 3'b100});
        check_burst("b2b_second", 16'h7000, w2);
        chk("b2b_no_overrun", 32'(bus16.overrun), 32'd0);
        pulse_done();

        // Coincident: last sample of frame 2 on the same cycle as fft_done.
        apply_reset();
        feed16(16'h4000, 1, -1);
        fork
            feed16(16'h5000, 1, FFT_SIZE - 1);
            check_burst("coin_first", 16'h4000, w1);
        join
        chk("coin_prime", {bus16.busy, bus16.fft_start, bus16.fft_load, bus16.overrun}, {28'd0, 4'b1000});
        check_burst("coin_second", 16'h5000, w2);
        chk("coin_latency", 32'(w2), 32'd0);
        pulse_done();

        // Reset in the middle of a load burst.
        apply_reset();
        feed16(16'h8000, 0, -1);
        @(negedge clk);
        repeat (200) @(negedge clk);
        chk("rst_pre_beat", {bus16.fft_load, bus16.add_rd, bus16.din}, {1'b1, 9'd200, 16'h80C8});
        reset = 1'b1;
        #1;
        chk("rst_mid_load", {bus16.fft_load, bus16.add_rd, bus16.din, bus16.fft_start, bus16.busy, bus16.overrun}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        feed16(16'h9000, 0, -1);
        chk("rst_fresh_prime", {bus16.busy, bus16.fft_load}, {30'd0, 2'b10});
        check_burst("rst_fresh", 16'h9000, w1);
        chk("rst_fresh_overrun", 32'(bus16.overrun), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
